// File: rtl/fetch_pkg.sv
// Shared fetch/decode definitions: datapath widths, canonical NOP and the
// {pc, instr} entry carried through the fetch buffer.
package fetch_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned INSTR_W = 32;

    // addi x0, x0, 0
    localparam logic [INSTR_W-1:0] RV_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: instruction memory port, redirect input and the
// valid/ready channel toward decode. master = fetch stage, slave = environment.
interface instr_fetch_if;
    import fetch_pkg::*;

    logic [XLEN-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               redirect_valid;
    logic [XLEN-1:0]    redirect_pc;
    logic               if_valid;
    logic               if_ready;
    logic [INSTR_W-1:0] if_instr;
    logic [XLEN-1:0]    if_pc;

    modport master (
        output imem_addr,
        input  imem_rdata,
        input  redirect_valid,
        input  redirect_pc,
        output if_valid,
        input  if_ready,
        output if_instr,
        output if_pc
    );

    modport slave (
        input  imem_addr,
        output imem_rdata,
        output redirect_valid,
        output redirect_pc,
        input  if_valid,
        output if_ready,
        input  if_instr,
        input  if_pc
    );

endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries with a synchronous flush that
// overrides push/pop. DEPTH must be a power of two, >= 2.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  fetch_entry_t wdata,
    output fetch_entry_t rdata,
    output logic         full,
    output logic         empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign rdata = mem[rd_ptr];
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: PC register, next-PC selection and buffering of {pc, instr}
// pairs for decode. Define IF_PERF_CNT_EN to add fetch/stall counters.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned     FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    instr_fetch_if.master      bus
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]        fetch_cnt,
    output logic [31:0]        stall_cnt
`endif
);

    logic [XLEN-1:0] pc;
    logic            push;
    logic            pop;
    logic            full;
    logic            empty;
    fetch_entry_t    wr_entry;
    fetch_entry_t    head;

    assign bus.imem_addr = {2'b00, pc[XLEN-1:2]};

    // A pop during redirect is still acknowledged; the flush discards the entry.
    assign pop  = bus.if_valid && bus.if_ready;
    assign push = !bus.redirect_valid && (!full || pop);

    assign wr_entry.pc    = pc;
    assign wr_entry.instr = bus.imem_rdata;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (bus.redirect_valid) begin
            pc <= {bus.redirect_pc[XLEN-1:2], 2'b00};
        end else if (push) begin
            pc <= pc + 32'd4;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (bus.redirect_valid),
        .push  (push),
        .pop   (pop),
        .wdata (wr_entry),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        bus.if_valid = !empty;
        bus.if_instr = RV_NOP;
        bus.if_pc    = '0;
        if (!empty) begin
            bus.if_instr = head.instr;
            bus.if_pc    = head.pc;
        end
    end

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (push) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
            if (bus.if_valid && !bus.if_ready) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
